// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge: FSM states, bus widths and
// the error read-back pattern.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int unsigned MMIO_ADDR_W = 21;
  localparam int unsigned DATA_W      = 32;
  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

endpackage

// File: rtl/mmio_bridge.sv
// Processor-bus to MMIO-controller bridge: IDLE -> ACCESS -> RESP with registered outputs.
// Optional MMIO_BRIDGE_ERR_EN adds bus_err and an error read pattern for out-of-window accesses.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [8:0]  BASE_ADDR    = 9'h1E0,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   bus_req,
  input  logic                   bus_we,
  input  logic [31:0]            bus_addr,
  input  logic [DATA_W-1:0]      bus_wdata,
  output logic                   bus_ack,
  output logic [DATA_W-1:0]      bus_rdata,
`ifdef MMIO_BRIDGE_ERR_EN
  output logic                   bus_err,
`endif
  output logic                   mmio_cs,
  output logic [MMIO_ADDR_W-1:0] mmio_address,
  output logic [DATA_W-1:0]      mmio_write_data,
  output logic                   mmio_write,
  output logic                   mmio_read,
  input  logic [DATA_W-1:0]      mmio_read_data
);

`ifdef MMIO_BRIDGE_ERR_EN
  localparam logic [DATA_W-1:0] OOW_RDATA = ERR_PATTERN;
`else
  localparam logic [DATA_W-1:0] OOW_RDATA = '0;
`endif

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   in_win_q, in_win_d;
  logic                   bus_ack_q, bus_ack_d;
  logic [DATA_W-1:0]      bus_rdata_q, bus_rdata_d;
  logic                   mmio_cs_q, mmio_cs_d;
  logic                   mmio_write_q, mmio_write_d;
  logic                   mmio_read_q, mmio_read_d;
  logic [MMIO_ADDR_W-1:0] mmio_address_q, mmio_address_d;
  logic [DATA_W-1:0]      mmio_write_data_q, mmio_write_data_d;
  logic                   bus_err_q, bus_err_d;
  logic                   hit;
  logic                   unused_addr_bits;

  // Byte-lane bits carry no meaning on a word-addressed controller.
  assign unused_addr_bits = ^bus_addr[1:0];
  assign hit = (bus_addr[31:23] == BASE_ADDR);

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    we_d              = we_q;
    in_win_d          = in_win_q;
    bus_ack_d         = 1'b0;
    bus_err_d         = 1'b0;
    bus_rdata_d       = bus_rdata_q;
    mmio_cs_d         = mmio_cs_q;
    mmio_write_d      = mmio_write_q;
    mmio_read_d       = mmio_read_q;
    mmio_address_d    = mmio_address_q;
    mmio_write_data_d = mmio_write_data_q;

    case (state_q)
      IDLE: begin
        if (bus_req) begin
          state_d           = ACCESS;
          we_d              = bus_we;
          in_win_d          = hit;
          mmio_address_d    = bus_addr[22:2];
          mmio_write_data_d = bus_wdata;
          bus_rdata_d       = '0;
          mmio_cs_d         = hit;
          mmio_write_d      = hit & bus_we;
          mmio_read_d       = hit & ~bus_we;
          // Only in-window reads stretch ACCESS; everything else takes one cycle.
          cnt_d             = (hit && !bus_we) ? 2'(READ_LATENCY) : 2'b00;
        end
      end
      ACCESS: begin
        if (cnt_q == 2'b00) begin
          state_d      = RESP;
          bus_ack_d    = 1'b1;
          bus_err_d    = ~in_win_q;
          mmio_cs_d    = 1'b0;
          mmio_write_d = 1'b0;
          mmio_read_d  = 1'b0;
          if (!we_q) begin
            bus_rdata_d = in_win_q ? mmio_read_data : OOW_RDATA;
          end
        end else begin
          cnt_d = cnt_q - 2'b01;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      we_q              <= 1'b0;
      in_win_q          <= 1'b0;
      bus_ack_q         <= 1'b0;
      bus_err_q         <= 1'b0;
      bus_rdata_q       <= '0;
      mmio_cs_q         <= 1'b0;
      mmio_write_q      <= 1'b0;
      mmio_read_q       <= 1'b0;
      mmio_address_q    <= '0;
      mmio_write_data_q <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      we_q              <= we_d;
      in_win_q          <= in_win_d;
      bus_ack_q         <= bus_ack_d;
      bus_err_q         <= bus_err_d;
      bus_rdata_q       <= bus_rdata_d;
      mmio_cs_q         <= mmio_cs_d;
      mmio_write_q      <= mmio_write_d;
      mmio_read_q       <= mmio_read_d;
      mmio_address_q    <= mmio_address_d;
      mmio_write_data_q <= mmio_write_data_d;
    end
  end

  assign bus_ack         = bus_ack_q;
  assign bus_rdata       = bus_rdata_q;
  assign mmio_cs         = mmio_cs_q;
  assign mmio_write      = mmio_write_q;
  assign mmio_read       = mmio_read_q;
  assign mmio_address    = mmio_address_q;
  assign mmio_write_data = mmio_write_data_q;
`ifdef MMIO_BRIDGE_ERR_EN
  assign bus_err = bus_err_q;
`else
  logic unused_err;
  assign unused_err = bus_err_q;
`endif

endmodule
